// File: rtl/scam_pkg.sv
// Shared constants, strobe bundle and window-mask helper for the SCA block controller.
package scam_pkg;

    localparam int unsigned SELC_PH    = 2;
    localparam int unsigned SELB_PH    = 3;
    localparam int unsigned SELD_PH    = 4;
    localparam int unsigned SELA_PH    = 5;
    localparam int unsigned PREEND_OFS = 2;
    localparam int unsigned NB_OFS     = 1;
    localparam int unsigned HIST_MAX   = 8;

    typedef struct packed {
        logic preend;
        logic nbsel;
        logic enareg;
        logic sela;
        logic selb;
        logic selc;
        logic seld;
        logic nolct;
        logic lctyena;
        logic wrena;
    } scam_strb_t;

    // Low w bits set, with w clamped to 1..hist.
    function automatic logic [HIST_MAX-1:0] win_mask(input int unsigned w, input int unsigned hist);
        int unsigned w_eff;
        logic [HIST_MAX-1:0] mask;
        w_eff = (w < 1) ? 1 : ((w > hist) ? hist : w);
        mask  = '0;
        for (int unsigned i = 0; i < HIST_MAX; i++) begin
            if (i < w_eff) mask[i] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/scam_lct_hist.sv
// Per-block LCT counting: saturating counter (optionally triplicated), block history
// shift register and the closed-block count latch.
module scam_lct_hist #(
    parameter int unsigned HIST  = 3,
    parameter int unsigned CNT_W = 4,
    parameter int unsigned TMR   = 0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_sync,
    input  logic             i_lct,
    input  logic             i_blk_end,
    output logic [HIST-1:0]  o_hist,
    output logic [CNT_W-1:0] o_lct_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] w_cnt;
    logic [CNT_W-1:0] w_cnt_sat;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [HIST-1:0]  r_hist;
    logic [CNT_W-1:0] r_lct_cnt;

    // An LCT in the closing cycle is folded into the closing block's count.
    assign w_cnt_sat = (i_lct && (w_cnt != CNT_MAX)) ? w_cnt + CNT_W'(1) : w_cnt;
    assign w_cnt_nxt = (i_sync || i_blk_end) ? '0 : w_cnt_sat;

    generate
        if (TMR != 0) begin : g_tmr
            logic [CNT_W-1:0] r_cnt_a;
            logic [CNT_W-1:0] r_cnt_b;
            logic [CNT_W-1:0] r_cnt_c;
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_cnt_a <= '0;
                    r_cnt_b <= '0;
                    r_cnt_c <= '0;
                end else begin
                    r_cnt_a <= w_cnt_nxt;
                    r_cnt_b <= w_cnt_nxt;
                    r_cnt_c <= w_cnt_nxt;
                end
            end
            assign w_cnt = (r_cnt_a & r_cnt_b) | (r_cnt_a & r_cnt_c) | (r_cnt_b & r_cnt_c);
        end else begin : g_single
            logic [CNT_W-1:0] r_cnt;
            always_ff @(posedge i_clk) begin
                if (i_rst) r_cnt <= '0;
                else       r_cnt <= w_cnt_nxt;
            end
            assign w_cnt = r_cnt;
        end
    endgenerate

    // History and count latch update only at block close; SYNC does not suppress them.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hist    <= '0;
            r_lct_cnt <= '0;
        end else if (i_blk_end) begin
            r_hist    <= {r_hist[HIST-2:0], (w_cnt != '0) | i_lct};
            r_lct_cnt <= w_cnt_sat;
        end
    end

    assign o_hist    = r_hist;
    assign o_lct_cnt = r_lct_cnt;

endmodule

// File: rtl/scam_blk_ctrl.sv
// SCA block controller: phase counter, write-select/strobe decode and dropped-block counter.
// Define SCAM_DROP_CNT_EN to build the DROP_CNT register; otherwise DROP_CNT is tied to 0.
module scam_blk_ctrl
    import scam_pkg::*;
#(
    parameter int unsigned BLK_LEN = 16,
    parameter int unsigned HIST    = 3,
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned DROP_W  = 16,
    parameter int unsigned TMR     = 0
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         SYNC,
    input  logic                         LCTDLY,
    input  logic                         DONE,
    input  logic                         NOGTRG,
    input  logic                         NODATA,
    input  logic                         FB_NODATA,
    input  logic                         SCND_BLK,
    input  logic                         SCND_SHARED,
    input  logic                         DLSCAFULL,
    input  logic                         DSCAFULL,
    input  logic                         MTCH_3BX,
    input  logic [$clog2(HIST+1)-1:0]    WIN,
    output logic [$clog2(BLK_LEN)-1:0]   STATE,
    output logic                         SELA,
    output logic                         SELB,
    output logic                         SELC,
    output logic                         SELD,
    output logic                         NOLCT,
    output logic                         WRENA,
    output logic                         LCTYENA,
    output logic                         ENAREG,
    output logic                         PREBLKEND,
    output logic                         NBSEL,
    output logic [CNT_W-1:0]             LCT_CNT,
    output logic [HIST-1:0]              LCT_HIST,
    output logic [DROP_W-1:0]            DROP_CNT
);

    localparam int unsigned SW = $clog2(BLK_LEN);
    localparam int unsigned E  = BLK_LEN - 1;

    logic [SW-1:0]       r_state;
    logic [HIST-1:0]     w_hist;
    logic [HIST_MAX-1:0] w_mask;
    logic [HIST_MAX-1:0] w_hist_ext;
    logic                w_llct;
    scam_strb_t          w_strb;

    always_ff @(posedge CLK) begin
        if (RST)       r_state <= '0;
        else if (SYNC) r_state <= '0;
        else           r_state <= r_state + SW'(1);
    end

    scam_lct_hist #(
        .HIST  (HIST),
        .CNT_W (CNT_W),
        .TMR   (TMR)
    ) u_lct_hist (
        .i_clk     (CLK),
        .i_rst     (RST),
        .i_sync    (SYNC),
        .i_lct     (LCTDLY),
        .i_blk_end (w_strb.preend),
        .o_hist    (w_hist),
        .o_lct_cnt (LCT_CNT)
    );

    assign w_mask     = win_mask(32'(WIN), HIST);
    assign w_hist_ext = HIST_MAX'(w_hist);
    assign w_llct     = |(w_hist_ext & w_mask);

    always_comb begin
        w_strb        = '0;
        w_strb.preend = (r_state == SW'(E - PREEND_OFS));
        w_strb.nbsel  = (r_state == SW'(E - NB_OFS));
        w_strb.enareg = (r_state == SW'(E));
        w_strb.sela   = (r_state == SW'(SELA_PH));
        w_strb.selb   = NOGTRG & ~DLSCAFULL & (r_state == SW'(SELB_PH));
        if (MTCH_3BX) begin
            w_strb.selc = DONE & SCND_BLK & ~SCND_SHARED & ~NODATA & (r_state == SW'(SELC_PH));
            w_strb.seld = DONE & SCND_BLK & ~FB_NODATA & (r_state == SW'(SELD_PH));
        end else begin
            w_strb.selc = DONE & ~NODATA & (r_state == SW'(SELC_PH));
        end
        w_strb.lctyena = w_llct & w_strb.nbsel;
        w_strb.nolct   = ~w_llct & ~DSCAFULL & w_strb.nbsel;
        w_strb.wrena   = w_strb.sela | w_strb.selb | w_strb.selc | w_strb.seld | w_strb.nolct;
    end

`ifdef SCAM_DROP_CNT_EN
    logic [DROP_W-1:0] r_drop_cnt;

    // Count blocks whose LCT could not be written because the SCA was full.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_drop_cnt <= '0;
        end else if (w_strb.nbsel && w_llct && DSCAFULL && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + DROP_W'(1);
        end
    end

    assign DROP_CNT = r_drop_cnt;
`else
    assign DROP_CNT = '0;
`endif

    assign STATE     = r_state;
    assign LCT_HIST  = w_hist;
    assign PREBLKEND = w_strb.preend;
    assign NBSEL     = w_strb.nbsel;
    assign ENAREG    = w_strb.enareg;
    assign SELA      = w_strb.sela;
    assign SELB      = w_strb.selb;
    assign SELC      = w_strb.selc;
    assign SELD      = w_strb.seld;
    assign NOLCT     = w_strb.nolct;
    assign LCTYENA   = w_strb.lctyena;
    assign WRENA     = w_strb.wrena;

endmodule

// File: tb/tb_scam_blk_ctrl.sv
// Scoreboard bench for scam_blk_ctrl (BLK_LEN=16, HIST=3, CNT_W=2).
module tb_scam_blk_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       SYNC = 1'b0, LCTDLY = 1'b0, DONE = 1'b0, NOGTRG = 1'b0, NODATA = 1'b0;
    logic       FB_NODATA = 1'b0, SCND_BLK = 1'b0, SCND_SHARED = 1'b0;
    logic       DLSCAFULL = 1'b0, DSCAFULL = 1'b0, MTCH_3BX = 1'b0;
    logic [1:0] WIN = 2'd2;
    logic [3:0] STATE;
    logic       SELA, SELB, SELC, SELD, NOLCT, WRENA, LCTYENA, ENAREG, PREBLKEND, NBSEL;
    logic [1:0] LCT_CNT;
    logic [2:0] LCT_HIST;
    logic [15:0] DROP_CNT;

    scam_blk_ctrl #(
        .BLK_LEN (16), .HIST (3), .CNT_W (2), .DROP_W (16), .TMR (0)
    ) dut (
        .CLK (CLK), .RST (RST), .SYNC (SYNC), .LCTDLY (LCTDLY), .DONE (DONE),
        .NOGTRG (NOGTRG), .NODATA (NODATA), .FB_NODATA (FB_NODATA), .SCND_BLK (SCND_BLK),
        .SCND_SHARED (SCND_SHARED), .DLSCAFULL (DLSCAFULL), .DSCAFULL (DSCAFULL),
        .MTCH_3BX (MTCH_3BX), .WIN (WIN), .STATE (STATE), .SELA (SELA), .SELB (SELB),
        .SELC (SELC), .SELD (SELD), .NOLCT (NOLCT), .WRENA (WRENA), .LCTYENA (LCTYENA),
        .ENAREG (ENAREG), .PREBLKEND (PREBLKEND), .NBSEL (NBSEL), .LCT_CNT (LCT_CNT),
        .LCT_HIST (LCT_HIST), .DROP_CNT (DROP_CNT)
    );

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] exp;
        string       name;
    } chk_t;

    chk_t sb[$];
    chk_t mc;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Strobe vector: {PREBLKEND,NBSEL,ENAREG,SELA,SELB,SELC,SELD,NOLCT,LCTYENA,WRENA}
    function automatic logic [31:0] act(input int sel);
        case (sel)
            0:       return 32'(STATE);
            1:       return 32'({PREBLKEND, NBSEL, ENAREG, SELA, SELB, SELC, SELD, NOLCT, LCTYENA, WRENA});
            2:       return 32'(LCT_CNT);
            3:       return 32'(LCT_HIST);
            default: return 32'(DROP_CNT);
        endcase
    endfunction

    function automatic logic [9:0] exp_strb(input int ph, input bit llct);
        logic pe, nb, en, sa, sbx, sc, sd, nl, ly, wr;
        pe  = (ph == 13);
        nb  = (ph == 14);
        en  = (ph == 15);
        sa  = (ph == 5);
        sbx = NOGTRG & ~DLSCAFULL & (ph == 3);
        if (MTCH_3BX) begin
            sc = DONE & SCND_BLK & ~SCND_SHARED & ~NODATA & (ph == 2);
            sd = DONE & SCND_BLK & ~FB_NODATA & (ph == 4);
        end else begin
            sc = DONE & ~NODATA & (ph == 2);
            sd = 1'b0;
        end
        nl = ~llct & ~DSCAFULL & nb;
        ly = llct & nb;
        wr = sa | sbx | sc | sd | nl;
        return {pe, nb, en, sa, sbx, sc, sd, nl, ly, wr};
    endfunction

    function automatic int drop_exp(input int n);
        int r;
        r = n;
`ifndef SCAM_DROP_CNT_EN
        r = 0;
`endif
        return r;
    endfunction

    task automatic push(input int sel, input logic [31:0] e, input string nm);
        chk_t c;
        c.cyc  = cyc;
        c.sel  = sel;
        c.exp  = e;
        c.name = nm;
        sb.push_back(c);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // One full block from phase 0; history/count checked at NBSEL, drop count after it.
    task automatic run_block(input logic [15:0] lct_at, input bit llct, input int cnt,
                             input int hist, input int drop);
        for (int ph = 0; ph < 16; ph++) begin
            LCTDLY = lct_at[ph];
            push(0, 32'(ph), $sformatf("state ph%0d", ph));
            push(1, 32'(exp_strb(ph, llct)), $sformatf("strobes ph%0d", ph));
            if (ph == 14) begin
                push(2, 32'(cnt), "lct_cnt");
                push(3, 32'(hist), "lct_hist");
            end
            if (ph == 15) push(4, 32'(drop), "drop_cnt");
            step();
        end
        LCTDLY = 1'b0;
    endtask

    always @(negedge CLK) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mc = sb.pop_front();
            n_vec++;
            if (mc.cyc != cyc) begin
                n_err++;
                $display("FAIL %s: check for cycle %0d not sampled (now %0d)", mc.name, mc.cyc, cyc);
            end else if (act(mc.sel) !== mc.exp) begin
                n_err++;
                $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", mc.name, cyc, act(mc.sel), mc.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        // Reset state, sampled in the first cycle after reset.
        push(3, 32'd0, "reset lct_hist");
        push(2, 32'd0, "reset lct_cnt");
        push(4, 32'd0, "reset drop_cnt");

        // Idle blocks, then a single LCT with WIN=2: visible for two blocks.
        run_block(16'h0000, 1'b0, 0, 3'b000, 0);
        run_block(16'h0000, 1'b0, 0, 3'b000, 0);
        run_block(16'h0080, 1'b1, 1, 3'b001, 0);
        run_block(16'h0000, 1'b1, 0, 3'b010, 0);
        run_block(16'h0000, 1'b0, 0, 3'b100, 0);
        run_block(16'h0000, 1'b0, 0, 3'b000, 0);

        // WIN=3: visible for three blocks.
        WIN = 2'd3;
        run_block(16'h0080, 1'b1, 1, 3'b001, 0);
        run_block(16'h0000, 1'b1, 0, 3'b010, 0);
        run_block(16'h0000, 1'b1, 0, 3'b100, 0);
        run_block(16'h0000, 1'b0, 0, 3'b000, 0);

        // Five LCTs saturate a 2-bit count.
        run_block(16'h02AA, 1'b1, 3, 3'b001, 0);
        // LCT exactly in the PREBLKEND cycle; WIN=0 clamps to 1.
        WIN = 2'd0;
        run_block(16'h2000, 1'b1, 1, 3'b011, 0);
        WIN = 2'd3;
        run_block(16'h0000, 1'b1, 0, 3'b110, 0);
        WIN = 2'd1;
        run_block(16'h0000, 1'b0, 0, 3'b100, 0);

        // Split mode, then normal mode with the same qualifiers plus NOGTRG.
        MTCH_3BX = 1'b1; DONE = 1'b1; SCND_BLK = 1'b1;
        run_block(16'h0000, 1'b0, 0, 3'b000, 0);
        MTCH_3BX = 1'b0; NOGTRG = 1'b1;
        run_block(16'h0000, 1'b0, 0, 3'b000, 0);
        DLSCAFULL = 1'b1; NODATA = 1'b1;
        run_block(16'h0000, 1'b0, 0, 3'b000, 0);
        DONE = 1'b0; SCND_BLK = 1'b0; NOGTRG = 1'b0; DLSCAFULL = 1'b0; NODATA = 1'b0;

        // SCA full with an LCT in each block.
        WIN = 2'd3; DSCAFULL = 1'b1;
        run_block(16'h0080, 1'b1, 1, 3'b001, drop_exp(1));
        run_block(16'h0080, 1'b1, 1, 3'b011, drop_exp(2));
        run_block(16'h0080, 1'b1, 1, 3'b111, drop_exp(3));
        run_block(16'h0000, 1'b1, 0, 3'b110, drop_exp(4));
        DSCAFULL = 1'b0;

        // SYNC at phase 9 after an LCT at phase 8: count discarded, history kept.
        for (int ph = 0; ph < 10; ph++) begin
            LCTDLY = (ph == 8);
            SYNC   = (ph == 9);
            push(0, 32'(ph), $sformatf("pre-sync state ph%0d", ph));
            push(1, 32'(exp_strb(ph, 1'b1)), $sformatf("pre-sync strobes ph%0d", ph));
            step();
        end
        LCTDLY = 1'b0; SYNC = 1'b0;
        push(0, 32'd0, "state after sync");
        push(3, 32'b110, "hist after sync");
        run_block(16'h0000, 1'b1, 0, 3'b100, drop_exp(4));

        // SYNC together with PREBLKEND and an LCT: block still closes normally.
        for (int ph = 0; ph < 14; ph++) begin
            LCTDLY = (ph == 13);
            SYNC   = (ph == 13);
            push(0, 32'(ph), $sformatf("pre-sync2 state ph%0d", ph));
            step();
        end
        LCTDLY = 1'b0; SYNC = 1'b0;
        push(0, 32'd0, "state after sync at preblkend");
        push(3, 32'b001, "hist after sync at preblkend");
        push(2, 32'd1, "lct_cnt after sync at preblkend");
        step(); step(); step();

        // RST and SYNC together.
        RST = 1'b1; SYNC = 1'b1;
        step();
        RST = 1'b0; SYNC = 1'b0;
        push(0, 32'd0, "state after rst+sync");
        push(3, 32'd0, "hist after rst+sync");
        push(2, 32'd0, "lct_cnt after rst+sync");
        push(4, 32'd0, "drop_cnt after rst+sync");
        push(1, 32'(exp_strb(0, 1'b0)), "strobes after rst+sync");
        step(); step();

        if (sb.size() != 0) begin
            n_err += sb.size();
            $display("FAIL scoreboard: %0d checks never sampled", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
